// File: rtl/rst_seq_if.sv
// rtl/rst_seq_if.sv - control and status bundle between the core and the reset sequencer
interface rst_seq_if;
    logic       swrst_i;
    logic       wdt_en_i;
    logic       wdt_clr_i;
    logic       periph_rst_o;
    logic       core_rst_o;
    logic [1:0] rst_cause_o;
    logic       wdt_to_o;

    modport master (
        output swrst_i, wdt_en_i, wdt_clr_i,
        input  periph_rst_o, core_rst_o, rst_cause_o, wdt_to_o
    );

    modport slave (
        input  swrst_i, wdt_en_i, wdt_clr_i,
        output periph_rst_o, core_rst_o, rst_cause_o, wdt_to_o
    );
endinterface

// File: rtl/rst_seq.sv
// rtl/rst_seq.sv - staged peripheral/core reset release with software and watchdog restart
module rst_seq #(
    parameter int STRETCH = 16,
    parameter int GAP     = 4,
    parameter int WDT_W   = 8
) (
    input  logic      clk,
    input  logic      rst_i,
    rst_seq_if.slave  bus
);
    typedef enum logic [1:0] {HOLD, PREL, RUN} state_t;

    localparam logic [7:0]       STRETCH_LAST = 8'(STRETCH - 1);
    localparam logic [7:0]       GAP_LAST     = 8'(GAP - 1);
    localparam logic [WDT_W-1:0] WDT_MAX      = {WDT_W{1'b1}};

    state_t           state_q, state_d;
    logic [7:0]       cnt_q, cnt_d;
    logic [WDT_W-1:0] wdt_q, wdt_d;
    logic             periph_q, periph_d;
    logic             core_q, core_d;
    logic [1:0]       cause_q, cause_d;
    logic             to_q, to_d;
    logic             timeout;

    // A kick on the terminal count wins, so all-ones can never wrap silently.
    assign timeout = (state_q == RUN) && bus.wdt_en_i && !bus.wdt_clr_i && (wdt_q == WDT_MAX);

    always_comb begin
        state_d  = state_q;
        cnt_d    = cnt_q;
        wdt_d    = '0;
        periph_d = periph_q;
        core_d   = core_q;
        cause_d  = cause_q;
        to_d     = 1'b0;
        case (state_q)
            HOLD: begin
                if (cnt_q == STRETCH_LAST) begin
                    state_d  = PREL;
                    cnt_d    = '0;
                    periph_d = 1'b0;
                end else begin
                    cnt_d = cnt_q + 8'd1;
                end
            end
            PREL: begin
                if (cnt_q == GAP_LAST) begin
                    state_d = RUN;
                    cnt_d   = '0;
                    core_d  = 1'b0;
                end else begin
                    cnt_d = cnt_q + 8'd1;
                end
            end
            RUN: begin
                if (bus.wdt_en_i && !bus.wdt_clr_i)
                    wdt_d = wdt_q + 1'b1;
                if (timeout) begin
                    state_d  = HOLD;
                    cnt_d    = '0;
                    wdt_d    = '0;
                    periph_d = 1'b1;
                    core_d   = 1'b1;
                    cause_d  = 2'b11;
                    to_d     = 1'b1;
                end else if (bus.swrst_i) begin
                    state_d  = HOLD;
                    cnt_d    = '0;
                    wdt_d    = '0;
                    periph_d = 1'b1;
                    core_d   = 1'b1;
                    cause_d  = 2'b10;
                end
            end
            default: begin
                state_d  = HOLD;
                cnt_d    = '0;
                periph_d = 1'b1;
                core_d   = 1'b1;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst_i) begin
            state_q  <= HOLD;
            cnt_q    <= '0;
            wdt_q    <= '0;
            periph_q <= 1'b1;
            core_q   <= 1'b1;
            cause_q  <= 2'b01;
            to_q     <= 1'b0;
        end else begin
            state_q  <= state_d;
            cnt_q    <= cnt_d;
            wdt_q    <= wdt_d;
            periph_q <= periph_d;
            core_q   <= core_d;
            cause_q  <= cause_d;
            to_q     <= to_d;
        end
    end

    assign bus.periph_rst_o = periph_q;
    assign bus.core_rst_o   = core_q;
    assign bus.rst_cause_o  = cause_q;
    assign bus.wdt_to_o     = to_q;
endmodule

// File: tb/tb_rst_seq.sv
// tb/tb_rst_seq.sv - directed self-checking bench for rst_seq
module tb_rst_seq;
    logic clk = 1'b0;
    logic rst_i;
    int   checks = 0;
    int   errors = 0;
    logic saw_to;

    rst_seq_if bus ();

    rst_seq #(.STRETCH(16), .GAP(4), .WDT_W(4)) dut (
        .clk   (clk),
        .rst_i (rst_i),
        .bus   (bus)
    );

    always #5 clk = ~clk;

    task automatic step(input int n);
        for (int i = 0; i < n; i++) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic chk(input string tag, input logic [7:0] obs, input logic [7:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic chk_out(input string tag, input logic p, input logic c,
                           input logic [1:0] cause, input logic to);
        chk({tag, ".periph"}, {7'd0, bus.periph_rst_o}, {7'd0, p});
        chk({tag, ".core"},   {7'd0, bus.core_rst_o},   {7'd0, c});
        chk({tag, ".cause"},  {6'd0, bus.rst_cause_o},  {6'd0, cause});
        chk({tag, ".wdt_to"}, {7'd0, bus.wdt_to_o},     {7'd0, to});
    endtask

    initial begin
        rst_i         = 1'b1;
        bus.swrst_i   = 1'b0;
        bus.wdt_en_i  = 1'b0;
        bus.wdt_clr_i = 1'b0;

        // power-on release: periph at E0+15, core at E0+19
        step(3);
        chk_out("por_reset", 1, 1, 2'b01, 0);
        rst_i = 1'b0;
        step(15);
        chk_out("por_e0p14", 1, 1, 2'b01, 0);
        step(1);
        chk_out("por_periph_rel", 0, 1, 2'b01, 0);
        step(3);
        chk_out("por_e0p18", 0, 1, 2'b01, 0);
        step(1);
        chk_out("por_core_rel", 0, 0, 2'b01, 0);

        // software reset in RUN, with ignored requests in HOLD and PREL
        bus.swrst_i = 1'b1;
        step(1);
        bus.swrst_i = 1'b0;
        chk_out("sw_assert", 1, 1, 2'b10, 0);
        step(4);
        bus.swrst_i = 1'b1;
        step(1);
        bus.swrst_i = 1'b0;
        chk_out("sw_in_hold", 1, 1, 2'b10, 0);
        step(10);
        chk_out("sw_r15", 1, 1, 2'b10, 0);
        step(1);
        chk_out("sw_periph_rel", 0, 1, 2'b10, 0);
        bus.swrst_i = 1'b1;
        step(1);
        bus.swrst_i = 1'b0;
        chk_out("sw_in_prel", 0, 1, 2'b10, 0);
        step(2);
        chk_out("sw_r19", 0, 1, 2'b10, 0);
        step(1);
        chk_out("sw_core_rel", 0, 0, 2'b10, 0);

        // watchdog timeout at the 16th edge after RUN entry, twice
        bus.wdt_en_i = 1'b1;
        step(15);
        chk_out("wdt_r15", 0, 0, 2'b10, 0);
        step(1);
        chk_out("wdt_timeout1", 1, 1, 2'b11, 1);
        step(1);
        chk_out("wdt_pulse_end", 1, 1, 2'b11, 0);
        step(18);
        chk_out("wdt_t19", 0, 1, 2'b11, 0);
        step(1);
        chk_out("wdt_t20_run", 0, 0, 2'b11, 0);
        step(15);
        chk_out("wdt_t35", 0, 0, 2'b11, 0);
        step(1);
        chk_out("wdt_timeout2", 1, 1, 2'b11, 1);

        // kicks every 10 cycles keep the watchdog quiet
        step(20);
        chk_out("kick_run", 0, 0, 2'b11, 0);
        saw_to = 1'b0;
        for (int i = 0; i < 200; i++) begin
            bus.wdt_clr_i = (i % 10 == 9);
            step(1);
            if (bus.wdt_to_o) saw_to = 1'b1;
        end
        bus.wdt_clr_i = 1'b0;
        chk("kick_no_timeout", {7'd0, saw_to}, 8'd0);
        chk_out("kick_after", 0, 0, 2'b11, 0);
        step(15);
        chk_out("kick_cnt15", 0, 0, 2'b11, 0);
        bus.wdt_clr_i = 1'b1;
        step(1);
        bus.wdt_clr_i = 1'b0;
        chk_out("kick_at_max", 0, 0, 2'b11, 0);
        step(15);
        chk_out("kick_restart15", 0, 0, 2'b11, 0);
        step(1);
        chk_out("kick_timeout", 1, 1, 2'b11, 1);

        // rst_i mid-PREL restarts the full sequence
        step(17);
        chk_out("mid_prel", 0, 1, 2'b11, 0);
        rst_i = 1'b1;
        step(1);
        rst_i = 1'b0;
        chk_out("mid_prel_rst", 1, 1, 2'b01, 0);
        step(15);
        chk_out("mid_e0p14", 1, 1, 2'b01, 0);
        step(1);
        chk_out("mid_periph_rel", 0, 1, 2'b01, 0);
        step(3);
        chk_out("mid_e0p18", 0, 1, 2'b01, 0);
        step(1);
        chk_out("mid_core_rel", 0, 0, 2'b01, 0);

        // swrst_i coinciding with a timeout reports the watchdog
        step(15);
        chk_out("coll_r15", 0, 0, 2'b01, 0);
        bus.swrst_i = 1'b1;
        step(1);
        bus.swrst_i = 1'b0;
        chk_out("coll_timeout", 1, 1, 2'b11, 1);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule

// File: doc/rst_seq.md
# rst_seq

Reset sequencer downstream of the reset bridge. It takes the bridge's synchronised active-high reset and stretches it. It releases peripheral reset and core reset in a fixed staged order. It re-enters the sequence on a software reset request or a watchdog timeout, and records the cause of the last reset for the core to read.

## Interface
- STRETCH, 16: cycles reset is held after `rst_i` deasserts before peripheral release; legal range 2..255.
- GAP, 4: cycles between peripheral release and core release; legal range 1..255.
- WDT_W, 8: watchdog counter width; timeout period is 2^WDT_W cycles.

Ports:
- clk  in  1  system clock; single clock domain.
- rst_i  in  1  reset from the bridge output; synchronous, active-high.
- swrst_i  in  1  software reset request; single-cycle pulse from the core.
- wdt_en_i  in  1  watchdog enable (level).
- wdt_clr_i  in  1  watchdog kick (pulse).
- periph_rst_o  out  1  peripheral reset; active-high, registered.
- core_rst_o  out  1  core reset; active-high, registered.
- rst_cause_o  out  2  cause of the last reset: 01 = external/POR, 10 = software, 11 = watchdog, 00 = never driven.
- wdt_to_o  out  1  one-cycle pulse marking a watchdog timeout.

## Operation
- **States:** HOLD, PREL (peripherals released), RUN. An 8-bit sequence counter `cnt` times HOLD and PREL.
- **rst_i = 1** (highest priority, any state), at the edge:
  - state = HOLD, cnt = 0, watchdog count = 0.
  - periph_rst_o = 1, core_rst_o = 1, rst_cause_o = 01, wdt_to_o = 0.
- **HOLD:**
  - cnt increments every cycle.
  - At the edge where cnt == STRETCH-1: go to PREL, cnt = 0, periph_rst_o = 0.
- **PREL:**
  - cnt increments every cycle.
  - At the edge where cnt == GAP-1: go to RUN, core_rst_o = 0.
- **RUN:**
  - swrst_i = 1: go to HOLD, cnt = 0, both reset outputs = 1, rst_cause_o = 10.
  - Watchdog timeout: go to HOLD, cnt = 0, both reset outputs = 1, rst_cause_o = 11, wdt_to_o = 1 for exactly one cycle.
  - Timeout takes priority over swrst_i when both occur on the same edge.
- **swrst_i outside RUN:** ignored; no restart, cause unchanged.
- **Watchdog counter** (WDT_W bits):
  - Counts only in RUN with wdt_en_i = 1.
  - wdt_clr_i = 1 loads 0.
  - Otherwise it increments.
  - Timeout occurs at an edge where count == all-ones and wdt_clr_i = 0.
  - wdt_clr_i on the same edge wins: no timeout, count = 0.
  - The counter is forced to 0 whenever not in RUN or wdt_en_i = 0.
  - The counter never wraps silently; all-ones always either times out or is cleared.
- **rst_cause_o:** holds its value until the next reset event.

## Timing
- E0 is the first edge sampling rst_i = 0.
- periph_rst_o falls at edge E0+STRETCH-1, i.e. after STRETCH edges low.
- core_rst_o falls at edge E0+STRETCH-1+GAP.
- Software or watchdog restart:
  - Both reset outputs rise at the edge sampling the request or timeout; no added latency.
  - The release sequence then repeats, with that edge playing the role of E0-1.
- Watchdog period: with wdt_en_i held high and no clears from RUN entry, the timeout occurs at the 2^WDT_W-th edge after RUN entry.
- Reset mid-sequence: rst_i in HOLD or PREL restarts the full STRETCH count. A partially elapsed count is never reused.
- The outputs are glitch-free registers, suitable for direct fanout as synchronous resets.

## Test plan
All scenarios use STRETCH=16, GAP=4, WDT_W=4.

1. **Power-on release.** Drive rst_i = 1 for 3 cycles, then 0.
   - periph_rst_o falls 16 edges after E0 (inclusive).
   - core_rst_o falls 4 edges later.
   - rst_cause_o = 01; wdt_to_o stays 0.
2. **Software reset.** Pulse swrst_i once in RUN.
   - Both resets are 1 after that edge.
   - periph releases 16 edges later and core 20 edges later.
   - rst_cause_o = 10.
3. **Watchdog timeout.** Hold wdt_en_i = 1 with no clears.
   - wdt_to_o pulses one cycle at the 16th edge after RUN entry; both resets assert.
   - rst_cause_o = 11; the sequence repeats and times out again.
4. **Watchdog kicks.** Pulse wdt_clr_i every 10 cycles for 200 cycles: no timeout. Then pulse wdt_clr_i exactly when the count is 15: no timeout, count returns to 0.
5. **Collisions and ignored requests.**
   - rst_i pulse mid-PREL: both outputs are 1 next cycle, cause = 01, full 16+4 restart.
   - swrst_i on the same edge as a timeout: cause = 11.
6. **swrst_i outside RUN.** Pulse swrst_i during HOLD and during PREL: no change to state, counter timing or rst_cause_o.
